// File: rtl/cordic_pkg.sv
// Constants and types shared by the rotation- and vectoring-mode CORDIC cores.
// Angles are stored at 20 fraction bits and rescaled to the datapath precision on use.
package cordic_pkg;

  localparam int SM_W     = 16;
  localparam int SM_FRAC  = 8;
  localparam int TBL_FRAC = 20;

  // atan(2^-i) for i = 0..15, Q.20
  localparam logic [31:0] ATAN_TBL [16] = '{
    32'd823550, 32'd486170, 32'd256879, 32'd130396,
    32'd65451,  32'd32757,  32'd16383,  32'd8192,
    32'd4096,   32'd2048,   32'd1024,   32'd512,
    32'd256,    32'd128,    32'd64,     32'd32
  };

  localparam logic [15:0] INV_K_Q16   = 16'd39797;
  localparam logic [31:0] PI_Q20      = 32'd3294199;
  localparam logic [31:0] HALF_PI_Q20 = 32'd1647100;
  localparam logic [14:0] PI_SM_MAG   = 15'h0324;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_SCALE
  } cstate_e;

  // Round a Q.20 table constant to fb fraction bits (fb <= 19).
  function automatic logic [31:0] from_q20(input logic [31:0] v, input int fb);
    logic [31:0] t;
    t = v >> (TBL_FRAC - 1 - fb);
    return (t + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/cordic_sm_conv.sv
// Sign-magnitude <-> two's-complement converter with magnitude clamp.
// TO_SM=0 widens a Q7.8 operand by SHIFT guard bits; TO_SM=1 rounds SHIFT bits away.
module cordic_sm_conv #(
  parameter int          IW      = 16,
  parameter int          OW      = 23,
  parameter bit          TO_SM   = 1'b0,
  parameter int          SHIFT   = 4,
  parameter logic [14:0] MAX_MAG = 15'h7FFF
) (
  input  logic [IW-1:0] a_i,
  output logic [OW-1:0] y_o,
  output logic          sat_o
);

  if (TO_SM) begin : g_to_sm
    localparam logic signed [IW:0] HALF = (IW + 1)'(1) << (SHIFT - 1);
    logic signed [IW:0] rnd;
    logic signed [IW:0] absv;
    logic [14:0]        m;
    logic               sat;

    always_comb begin
      rnd   = ($signed({a_i[IW-1], a_i}) + HALF) >>> SHIFT;
      absv  = rnd[IW] ? -rnd : rnd;
      sat   = absv > $signed({{(IW - 14){1'b0}}, MAX_MAG});
      m     = sat ? MAX_MAG : absv[14:0];
      // a result that rounds to zero always leaves with a positive sign
      y_o   = OW'({rnd[IW] && (m != '0), m});
      sat_o = sat;
    end
  end else begin : g_to_tc
    logic [14:0]   m;
    logic [OW-1:0] ext;
    logic          sat;

    always_comb begin
      sat   = a_i[14:0] > MAX_MAG;
      m     = sat ? MAX_MAG : a_i[14:0];
      ext   = OW'({m, {SHIFT{1'b0}}});
      y_o   = a_i[IW-1] ? -ext : ext;
      sat_o = sat;
    end
  end

endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: (x, y) in sign-magnitude Q7.8 -> (magnitude, angle).
// One shared add/sub datapath with a barrel shift, ITER+2 cycles per result.
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int ITER  = 12,
  parameter int GUARD = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] x_in,
  input  logic [15:0] y_in,
  output logic [15:0] mag,
  output logic [15:0] ang,
  output logic        ovf,
  output logic        busy,
  output logic        done
);

  localparam int W  = 19 + GUARD;
  localparam int FB = SM_FRAC + GUARD;
  localparam logic [3:0] LAST = 4'(ITER - 1);
  localparam logic signed [W-1:0] PI_W = W'(from_q20(PI_Q20, FB));

  cstate_e             state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic signed [W-1:0] x_q, y_q, z_q, x_d, y_d, z_d;
  logic                zero_q, zero_d;
  logic signed [W-1:0] x_tc, y_tc, xs, ys, atan_w, mag_tc;
  logic signed [W+16:0] prod;
  logic [15:0]         mag_q, ang_q, mag_sm, ang_sm;
  logic                ovf_q, done_q, mag_sat;

  cordic_sm_conv #(.IW(16), .OW(W), .TO_SM(1'b0), .SHIFT(GUARD), .MAX_MAG(15'h7FFF))
    u_x_in (.a_i(x_in), .y_o(x_tc), .sat_o());
  cordic_sm_conv #(.IW(16), .OW(W), .TO_SM(1'b0), .SHIFT(GUARD), .MAX_MAG(15'h7FFF))
    u_y_in (.a_i(y_in), .y_o(y_tc), .sat_o());
  cordic_sm_conv #(.IW(W), .OW(16), .TO_SM(1'b1), .SHIFT(GUARD), .MAX_MAG(15'h7FFF))
    u_mag_out (.a_i(mag_tc), .y_o(mag_sm), .sat_o(mag_sat));
  cordic_sm_conv #(.IW(W), .OW(16), .TO_SM(1'b1), .SHIFT(GUARD), .MAX_MAG(PI_SM_MAG))
    u_ang_out (.a_i(z_q), .y_o(ang_sm), .sat_o());

  // Gain compensation: truncated multiply by 1/K in Q.16
  assign prod   = x_q * $signed({1'b0, INV_K_Q16});
  assign mag_tc = W'(prod >>> 16);

  always_comb begin
    xs     = x_q >>> cnt_q;
    ys     = y_q >>> cnt_q;
    atan_w = W'(from_q20(ATAN_TBL[cnt_q], FB));
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    zero_d = zero_q;
    cnt_d  = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d  = '0;
          zero_d = (x_tc == '0) && (y_tc == '0);
          // left half-plane: rotate by pi so the iterations only see x >= 0
          if (x_tc[W-1]) begin
            x_d = -x_tc;
            y_d = -y_tc;
            z_d = y_tc[W-1] ? -PI_W : PI_W;
          end else begin
            x_d = x_tc;
            y_d = y_tc;
            z_d = '0;
          end
        end
      end
      ST_ITER: begin
        cnt_d = cnt_q + 4'd1;
        if (!y_q[W-1]) begin
          x_d = x_q + ys;
          y_d = y_q - xs;
          z_d = z_q + atan_w;
        end else begin
          x_d = x_q - ys;
          y_d = y_q + xs;
          z_d = z_q - atan_w;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    x_q    <= x_d;
    y_q    <= y_d;
    z_q    <= z_d;
    zero_q <= zero_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mag_q   <= '0;
      ang_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= (state_q == ST_SCALE);
      if (state_q == ST_SCALE) begin
        mag_q <= mag_sm;
        ang_q <= zero_q ? 16'h0000 : ang_sm;
        ovf_q <= mag_sat;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_ITER;
      ST_ITER:  if (cnt_q == LAST) state_d = ST_SCALE;
      ST_SCALE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
    done = done_q;
    mag  = mag_q;
    ang  = ang_q;
    ovf  = ovf_q;
  end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Scoreboard bench for cordic_vectoring: directed vectors with hand-computed polar results.
module tb_cordic_vectoring;

  localparam int ITER = 12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] x_in = '0;
  logic [15:0] y_in = '0;
  logic [15:0] mag, ang;
  logic        ovf, busy, done;

  always #5 clk = ~clk;

  cordic_vectoring #(.ITER(ITER), .GUARD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .x_in  (x_in),
    .y_in  (y_in),
    .mag   (mag),
    .ang   (ang),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  typedef struct {
    string       name;
    logic [15:0] mag;
    logic [15:0] ang;
    logic        ovf;
    int          mtol;
    int          atol;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   dones = 0;
  int   issued = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sm2int(input logic [15:0] v);
    return v[15] ? -int'(v[14:0]) : int'(v[14:0]);
  endfunction

  task automatic check_eq(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // tol 0 demands the exact bit pattern (so -0 is distinguished from +0)
  task automatic check_near(input string nm, input logic [15:0] act, input logic [15:0] exp,
                            input int tol);
    int d;
    checks++;
    d = sm2int(act) - sm2int(exp);
    if ((tol == 0 && act !== exp) || d > tol || d < -tol) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h tol %0d", nm, act, exp, tol);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (done) begin
        dones++;
        check_eq("done_single_pulse", int'(prev_done), 0);
        check_eq("busy_low_in_done", int'(busy), 0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: mag=0x%04h ang=0x%04h at cycle %0d", mag, ang, cyc);
        end else begin
          e = sb.pop_front();
          check_near({e.name, "_mag"}, mag, e.mag, e.mtol);
          check_near({e.name, "_ang"}, ang, e.ang, e.atol);
          check_eq({e.name, "_ovf"}, int'(ovf), int'(e.ovf));
          check_eq({e.name, "_latency"}, cyc, e.cyc);
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Caller is positioned at a negedge; start is sampled at the following posedge.
  task automatic issue_now(input string nm, input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] m, input logic [15:0] a, input logic o,
                           input int mt, input int at);
    exp_t e;
    e.name = nm; e.mag = m; e.ang = a; e.ovf = o; e.mtol = mt; e.atol = at;
    e.cyc  = cyc + ITER + 2;
    sb.push_back(e);
    issued++;
    x_in  = x;
    y_in  = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    x_in  = 16'($urandom);
    y_in  = 16'($urandom);
    check_eq({nm, "_busy"}, int'(busy), 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d results outstanding after %0d cycles", sb.size(), budget);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic vec(input string nm, input logic [15:0] x, input logic [15:0] y,
                     input logic [15:0] m, input logic [15:0] a, input logic o,
                     input int mt, input int at);
    @(negedge clk);
    issue_now(nm, x, y, m, a, o, mt, at);
    wait_idle(60);
  endtask

  initial begin
    int n;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_mag", int'(mag), 0);
    check_eq("reset_ang", int'(ang), 0);
    check_eq("reset_ovf", int'(ovf), 0);
    check_eq("reset_busy", int'(busy), 0);
    check_eq("reset_done", int'(done), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    vec("basic_3_4",    16'h0300, 16'h0400, 16'h0500, 16'h00ED, 1'b0, 2, 2);
    vec("negx_y0",      16'h8100, 16'h0000, 16'h0100, 16'h0324, 1'b0, 2, 2);
    vec("negx_negy",    16'h8100, 16'h8001, 16'h0100, 16'h8324, 1'b0, 2, 2);
    vec("neg_y_axis",   16'h0000, 16'h8200, 16'h0200, 16'h8192, 1'b0, 2, 2);
    vec("saturate",     16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h00C9, 1'b1, 0, 2);
    vec("minus_zero",   16'h8000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 0, 0);
    vec("zero_zero",    16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 0, 0);
    vec("pos_x_axis",   16'h0100, 16'h0000, 16'h0100, 16'h0000, 1'b0, 2, 2);
    vec("q4_diag",      16'h0200, 16'h8200, 16'h02D4, 16'h80C9, 1'b0, 2, 2);
    vec("q2_3_4",       16'h8300, 16'h0400, 16'h0500, 16'h0237, 1'b0, 2, 2);

    // second start while busy must be dropped
    @(negedge clk);
    issue_now("busy_first", 16'h0300, 16'h0400, 16'h0500, 16'h00ED, 1'b0, 2, 2);
    repeat (4) @(negedge clk);
    x_in = 16'h0100; y_in = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(60);
    repeat (20) @(negedge clk);
    check_eq("ignored_start_done_count", dones, issued);

    // start raised in the done cycle is accepted immediately
    @(negedge clk);
    issue_now("b2b_first", 16'h0000, 16'h8200, 16'h0200, 16'h8192, 1'b0, 2, 2);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    check_eq("b2b_done_seen", int'(done), 1);
    issue_now("b2b_second", 16'h0300, 16'h0400, 16'h0500, 16'h00ED, 1'b0, 2, 2);
    wait_idle(60);

    // reset in the middle of an operation discards it
    @(negedge clk);
    issue_now("reset_victim", 16'h0200, 16'h8200, 16'h02D4, 16'h80C9, 1'b0, 2, 2);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    sb.delete();
    issued--;
    check_eq("midreset_mag", int'(mag), 0);
    check_eq("midreset_ang", int'(ang), 0);
    check_eq("midreset_ovf", int'(ovf), 0);
    check_eq("midreset_busy", int'(busy), 0);
    check_eq("midreset_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("midreset_no_done", dones, issued);
    vec("after_reset",  16'h8300, 16'h0400, 16'h0500, 16'h0237, 1'b0, 2, 2);
    check_eq("final_done_count", dones, issued);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cordic_vectoring.md
# cordic_vectoring

Iterative CORDIC engine in vectoring mode: converts a Cartesian pair (x, y) into polar form (magnitude, angle). It is the inverse-direction companion to the existing rotation-mode `cordic` core: rotation maps angle to coordinates, and this block maps coordinates back to angle. Both share the same 16-bit sign-magnitude operand format, so results can be looped through either core.

## Interface
- `ITER`, default 12: number of micro-rotations; legal range 8–15.
- `GUARD`, default 4: extra fractional guard bits in the internal datapath.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `start`  in  1: request; sampled only in IDLE.
- `x_in`  in  16: x operand, sign-magnitude Q7.8 (bit15 sign, bits14:8 integer, bits7:0 fraction).
- `y_in`  in  16: y operand, same format.
- `mag`  out  16: magnitude, sign-magnitude Q7.8; bit15 is always 0.
- `ang`  out  16: angle in radians, sign-magnitude Q7.8, range [−π, +π].
- `ovf`  out  1: magnitude saturated; valid with `done`, then held.
- `busy`  out  1: high from the accepted start until `done`.
- `done`  out  1: one-cycle pulse when `mag`/`ang`/`ovf` update.

## Operation
- **States:** IDLE → ITER → SCALE → IDLE.
- **IDLE, `start`=1 at an edge:**
  - Capture the inputs and convert them to two's complement, internal width W = 19+GUARD (sign, 10 integer, 8+GUARD fraction).
  - A magnitude of zero with sign 1 (−0) is treated as 0.
- **Pre-rotation:**
  - If x<0: negate x and y, and set z0 = +π if the original y≥0, otherwise −π.
  - Otherwise z0 = 0.
- **ITER, step i = 0..ITER−1, one per cycle:**
  - If y≥0: x+=y>>>i, y−=x>>>i, z+=atan(2^−i).
  - Otherwise: x−=y>>>i, y+=x>>>i, z−=atan(2^−i).
  - All right-hand sides use the pre-step values, with an arithmetic shift.
- **SCALE:**
  - mag = x·(1/K), with 1/K = 0.607253, as a truncated constant multiply.
  - Round both mag and z to nearest at 8 fraction bits.
  - Convert to sign-magnitude.
  - If the magnitude exceeds 0x7FFF: mag = 0x7FFF and ovf = 1.
  - Angle 0 is emitted as 0x0000, never 0x8000.
  - Angle magnitude is clamped to π (0x0324).
- **Zero input:** (0,0) yields mag=0x0000, ang=0x0000, ovf=0.
- **Accuracy:** ≤2 LSB error on both mag and ang for ITER≥12 when not saturated.
- **Output holding:** outputs hold their last result until the next `done`.

## Timing
- **Reset values:** `mag`=0, `ang`=0, `ovf`=0, `busy`=0, `done`=0, state IDLE, iteration counter 0.
- **Latency:**
  - Start sampled at edge E0.
  - `busy` is high from E0.
  - Iterations occur on edges E1..E_ITER.
  - SCALE occurs at edge E_ITER+1.
  - `done`=1 and `busy`=0 during the cycle after E_ITER+1; with the default ITER=12, `done` follows 13 edges after the start edge.
- **`start` while busy:** ignored, with no queueing.
- **`start` high in the `done` cycle:** accepted, since the block is back in IDLE; back-to-back throughput is one result per ITER+2 cycles.
- **Input stability:** `x_in`/`y_in` need only be valid at the start edge.
- **Reset mid-operation:** immediate return to reset values; the partial result is discarded and no `done` is issued.

## Structure
- **Package `cordic_pkg` (shared with the rotation core):**
  - Operand width 16 and fraction width 8.
  - atan(2^−i) table for i=0..15 at 8+GUARD fraction bits.
  - 1/K constant.
  - π and π/2 constants.
  - State enum.
- **Sub-module `cordic_sm_conv`:**
  - Sign-magnitude ↔ two's-complement conversion, including −0 normalisation and saturation.
  - Instantiated twice on input (x, y) and twice on output (mag, ang).
- **Datapath:** one shared add/subtract datapath with a barrel shift by the iteration count; no unrolled pipeline.

## Test plan
- **Basic vector:** x=0x0300 (3.0), y=0x0400 (4.0) → mag 0x0500 ±2, ang 0x00ED ±2 (0.9273 rad), ovf=0.
- **Negative x, π pre-rotation:** x=0x8100 (−1.0), y=0x0000 → mag 0x0100 ±2, ang 0x0324 ±2 (+π); repeat with y=0x8001 → ang ≈ 0x8324.
- **Negative y-axis:** x=0x0000, y=0x8200 (−2.0) → mag 0x0200 ±2, ang 0x8192 ±2 (−π/2).
- **Saturation:** x=0x7FFF, y=0x7FFF → mag 0x7FFF, ovf=1, ang 0x00C9 ±2 (π/4).
- **Zero and −0:** x=0x8000, y=0x0000 → mag 0x0000, ang 0x0000 (not 0x8000), ovf=0.
- **Handshake and reset:**
  - `done` is a single pulse exactly ITER+1 edges after the start edge.
  - A second `start` while busy is ignored, and outputs change only once.
  - `start` in the `done` cycle is accepted.
  - `reset` pulsed low during ITER → all outputs return to 0, no `done` is issued, and the next start completes normally.
